sysid_checker: RTL and testbench

Avalon-MM read master that sits directly upstream of the system-ID slave and consumes its output. On start it reads word 0 (ID) and word 1 (timestamp), then compares both against expected values. It reports pass/fail and timeout status to boot/reset-control logic, so a bitstream/software mismatch is flagged before the game core is released.

---
 rtl/sysid_pkg.sv | 20 ++
 rtl/sysid_read_timer.sv | 33 +++
 rtl/sysid_checker.sv | 155 +++++++++++++++
 tb/tb_sysid_checker.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID checker.
package sysid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    RD_TS,
    COMPARE,
    FIN
  } sysid_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam int SYSID_DATA_W = 32;

  localparam logic [SYSID_DATA_W-1:0] SYSID_EXPECTED_ID_DEF = 32'd0;
  localparam logic [SYSID_DATA_W-1:0] SYSID_EXPECTED_TS_DEF = 32'd1513105036;

endpackage

// File: rtl/sysid_read_timer.sv
// Per-read waitrequest counter with retry bookkeeping; expire = reissue now, exhausted = give up.
module sysid_read_timer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRIES    = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expire,
  output logic exhausted
);

  logic [15:0] wait_cnt;
  logic [3:0]  retry_cnt;

  // tick on the edge that completes the TIMEOUT_CYCLES-th stalled cycle
  assign expire    = tick && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign exhausted = expire && (retry_cnt == 4'(MAX_RETRIES));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wait_cnt  <= '0;
      retry_cnt <= '0;
    end else if (expire) begin
      wait_cnt  <= '0;
      retry_cnt <= retry_cnt + 4'd1;
    end else if (tick) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches sysid ID/timestamp and flags a mismatch.
// Optional macro SYSID_CHECK_AUTO_START_EN: run one check automatically after reset release.
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID        = SYSID_EXPECTED_ID_DEF,
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_TIMESTAMP = SYSID_EXPECTED_TS_DEF,
  parameter int                      TIMEOUT_CYCLES     = 255,
  parameter int                      MAX_RETRIES        = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic                    avm_address,
  output logic                    avm_read,
  input  logic                    avm_waitrequest,
  input  logic [SYSID_DATA_W-1:0] avm_readdata,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    id_ok,
  output logic                    ts_ok,
  output logic                    timeout_err,
  output logic [SYSID_DATA_W-1:0] id_value,
  output logic [SYSID_DATA_W-1:0] ts_value
);

  sysid_state_t state_q, state_d;

  logic                    read_d, addr_d, busy_d, done_d, pass_d;
  logic                    id_ok_d, ts_ok_d, terr_d;
  logic [SYSID_DATA_W-1:0] id_d, ts_d;
  logic                    timer_clr, expire, exhausted;
  logic                    start_eff;

`ifdef SYSID_CHECK_AUTO_START_EN
  logic auto_pend;

  always_ff @(posedge clock) begin
    if (reset) auto_pend <= 1'b1;
    else       auto_pend <= 1'b0;
  end

  assign start_eff = start | auto_pend;
`else
  assign start_eff = start;
`endif

  sysid_read_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .MAX_RETRIES   (MAX_RETRIES)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (timer_clr),
    .tick     (avm_read && avm_waitrequest),
    .expire   (expire),
    .exhausted(exhausted)
  );

  always_comb begin
    state_d   = state_q;
    read_d    = 1'b0;
    addr_d    = avm_address;
    busy_d    = busy;
    done_d    = done;
    pass_d    = pass;
    id_ok_d   = id_ok;
    ts_ok_d   = ts_ok;
    terr_d    = timeout_err;
    id_d      = id_value;
    ts_d      = ts_value;
    timer_clr = 1'b0;

    case (state_q)
      IDLE, FIN: begin
        if (start_eff) begin
          state_d   = RD_ID;
          read_d    = 1'b1;
          addr_d    = SYSID_ADDR_ID;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          terr_d    = 1'b0;
          timer_clr = 1'b1;
        end
      end
      RD_ID, RD_TS: begin
        read_d = 1'b1;
        // avm_read low here means the one-cycle retry gap; just reissue
        if (avm_read && !avm_waitrequest) begin
          if (state_q == RD_ID) begin
            id_d      = avm_readdata;
            state_d   = RD_TS;
            addr_d    = SYSID_ADDR_TS;
            timer_clr = 1'b1;
          end else begin
            ts_d    = avm_readdata;
            state_d = COMPARE;
            read_d  = 1'b0;
          end
        end else if (exhausted) begin
          state_d = FIN;
          read_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          terr_d  = 1'b1;
        end else if (expire) begin
          read_d = 1'b0;
        end
      end
      COMPARE: begin
        id_ok_d = (id_value == EXPECTED_ID);
        ts_ok_d = (ts_value == EXPECTED_TIMESTAMP);
        pass_d  = id_ok_d && ts_ok_d && !timeout_err;
        state_d = FIN;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      avm_read    <= 1'b0;
      avm_address <= SYSID_ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      state_q     <= state_d;
      avm_read    <= read_d;
      avm_address <= addr_d;
      busy        <= busy_d;
      done        <= done_d;
      pass        <= pass_d;
      id_ok       <= id_ok_d;
      ts_ok       <= ts_ok_d;
      timeout_err <= terr_d;
      id_value    <= id_d;
      ts_value    <= ts_d;
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: default instance plus a short-timeout instance.
module tb_sysid_checker;
  import sysid_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, start_to;
  logic        avm_address, avm_read, wr;
  logic [31:0] rdata, id_word, ts_word;
  logic        busy, done, pass, id_ok, ts_ok, timeout_err;
  logic [31:0] id_value, ts_value;

  logic        to_address, to_read, to_busy, to_done, to_pass, to_id_ok, to_ts_ok, to_terr;
  logic [31:0] to_id_value, to_ts_value;
  logic [31:0] to_rdata;

  logic        stall_ts_en, mon_clr;
  int          ts_stall_cnt, ts_rd_cyc, addr_bad;
  int          to_rd_cyc, to_rises, to_gaps;
  logic        prev_rdwr, prev_addr, to_read_prev;

  int n_checks = 0;
  int n_err    = 0;

  sysid_checker dut (
    .clock          (clk),
    .reset          (reset),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(wr),
    .avm_readdata   (rdata),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .id_ok          (id_ok),
    .ts_ok          (ts_ok),
    .timeout_err    (timeout_err),
    .id_value       (id_value),
    .ts_value       (ts_value)
  );

  sysid_checker #(.TIMEOUT_CYCLES(4), .MAX_RETRIES(2)) dut_to (
    .clock          (clk),
    .reset          (reset),
    .start          (start_to),
    .avm_address    (to_address),
    .avm_read       (to_read),
    .avm_waitrequest(1'b1),
    .avm_readdata   (to_rdata),
    .busy           (to_busy),
    .done           (to_done),
    .pass           (to_pass),
    .id_ok          (to_id_ok),
    .ts_ok          (to_ts_ok),
    .timeout_err    (to_terr),
    .id_value       (to_id_value),
    .ts_value       (to_ts_value)
  );

  assign to_rdata = 32'h0;
  assign rdata    = avm_address ? ts_word : id_word;
  assign wr       = stall_ts_en && avm_read && avm_address && (ts_stall_cnt < 5);

  always @(posedge clk) begin
    if (mon_clr) begin
      ts_stall_cnt <= 0;
      ts_rd_cyc    <= 0;
      addr_bad     <= 0;
      to_rd_cyc    <= 0;
      to_rises     <= 0;
      to_gaps      <= 0;
      prev_rdwr    <= 1'b0;
      prev_addr    <= 1'b0;
      to_read_prev <= 1'b0;
    end else begin
      if (wr) ts_stall_cnt <= ts_stall_cnt + 1;
      if (avm_read && avm_address) ts_rd_cyc <= ts_rd_cyc + 1;
      if (avm_read && prev_rdwr && avm_address != prev_addr) addr_bad <= addr_bad + 1;
      prev_rdwr <= avm_read && wr;
      prev_addr <= avm_address;
      if (to_read) to_rd_cyc <= to_rd_cyc + 1;
      if (to_read && !to_read_prev) to_rises <= to_rises + 1;
      if (!to_read && to_busy) to_gaps <= to_gaps + 1;
      to_read_prev <= to_read;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_done"}, done, 1'b1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_to = 1'b0;
    stall_ts_en = 1'b0; mon_clr = 1'b1;
    id_word = 32'd0; ts_word = 32'd1513105036;
    tick(); tick();

    // reset state
    check("rst_read", avm_read, 1'b0);
    check("rst_addr", avm_address, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_terr", timeout_err, 1'b0);
    check("rst_id", id_value, 32'd0);
    check("rst_ts", ts_value, 32'd0);
    reset = 1'b0;
    mon_clr = 1'b0;

    // no external start: idle unless auto-start is built in
    repeat (10) tick();
`ifdef SYSID_CHECK_AUTO_START_EN
    check("auto_done", done, 1'b1);
    check("auto_pass", pass, 1'b1);
`else
    check("noauto_done", done, 1'b0);
    check("noauto_busy", busy, 1'b0);
    check("noauto_read", avm_read, 1'b0);
`endif

    // zero-wait cycle-accurate run
    pulse_start();
    check("t1_n1_read", avm_read, 1'b1);
    check("t1_n1_addr", avm_address, 1'b0);
    check("t1_n1_busy", busy, 1'b1);
    check("t1_n1_done", done, 1'b0);
    tick();
    check("t1_n2_read", avm_read, 1'b1);
    check("t1_n2_addr", avm_address, 1'b1);
    tick();
    check("t1_n3_read", avm_read, 1'b0);
    check("t1_n3_done", done, 1'b0);
    tick();
    check("t1_n4_done", done, 1'b1);
    check("t1_pass", pass, 1'b1);
    check("t1_id_ok", id_ok, 1'b1);
    check("t1_ts_ok", ts_ok, 1'b1);
    check("t1_busy", busy, 1'b0);
    check("t1_id", id_value, 32'd0);
    check("t1_ts", ts_value, 32'd1513105036);

    // wrong ID
    id_word = 32'h0000_0001;
    pulse_start();
    wait_done("t2");
    check("t2_id_ok", id_ok, 1'b0);
    check("t2_ts_ok", ts_ok, 1'b1);
    check("t2_pass", pass, 1'b0);
    check("t2_id", id_value, 32'h1);
    id_word = 32'd0;

    // 5 stall cycles on word 1, below timeout
    stall_ts_en = 1'b1;
    clear_mon();
    pulse_start();
    wait_done("t3");
    check("t3_ts_cycles", ts_rd_cyc, 6);
    check("t3_addr_bad", addr_bad, 0);
    check("t3_pass", pass, 1'b1);
    check("t3_terr", timeout_err, 1'b0);

    // stuck waitrequest on the short-timeout instance
    clear_mon();
    start_to = 1'b1;
    tick();
    start_to = 1'b0;
    begin
      int n;
      n = 0;
      while (!to_done && n < 100) begin
        tick();
        n++;
      end
    end
    check("t4_done", to_done, 1'b1);
    check("t4_terr", to_terr, 1'b1);
    check("t4_pass", to_pass, 1'b0);
    check("t4_id_ok", to_id_ok, 1'b0);
    check("t4_read_cycles", to_rd_cyc, 12);
    check("t4_attempts", to_rises, 3);
    check("t4_gaps", to_gaps, 2);

    // start during RD_TS is ignored
    clear_mon();
    pulse_start();
    begin
      int n;
      n = 0;
      while (!avm_address && n < 20) begin
        tick();
        n++;
      end
    end
    check("t5_in_rdts", avm_address, 1'b1);
    pulse_start();
    wait_done("t5");
    check("t5_ts_cycles", ts_rd_cyc, 6);
    check("t5_pass", pass, 1'b1);
    repeat (3) tick();
    check("t5_idle_busy", busy, 1'b0);

    // reset in the middle of a second run
    pulse_start();
    check("t5b_read_before", avm_read, 1'b1);
    reset = 1'b1;
    tick();
    check("t5b_read", avm_read, 1'b0);
    check("t5b_busy", busy, 1'b0);
    check("t5b_done", done, 1'b0);
    check("t5b_pass", pass, 1'b0);
    check("t5b_id", id_value, 32'd0);
    check("t5b_ts", ts_value, 32'd0);
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
